// File: rtl/s011hd1p_x32y2d128_bw.sv
// Single-port 64x128 synchronous SRAM with per-bit active-low write mask and registered read data.
// Optional build macro SRAM_CLEAR_ON_RESET_EN also clears the whole array on reset.
module s011hd1p_x32y2d128_bw #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CEN,
    input  logic                  WEN,
    input  logic [DATA_WIDTH-1:0] BWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] merged;

    // Reset has priority: any access presented alongside rst is dropped.
    assign rd_en  = !rst && !CEN &&  WEN;
    assign wr_en  = !rst && !CEN && !WEN;
    assign merged = (mem[A] & BWEN) | (D & ~BWEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (rd_en) begin
            Q <= mem[A];
        end
    end

`ifdef SRAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[A] <= merged;
        end
    end
`else
    // NOTE: the array has no reset term, so it maps to a plain RAM macro rather than flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[A] <= merged;
        end
    end
`endif

endmodule

// File: tb/tb_s011hd1p_x32y2d128_bw.sv
// Directed self-checking bench for s011hd1p_x32y2d128_bw; expectations follow SRAM_CLEAR_ON_RESET_EN.
module tb_s011hd1p_x32y2d128_bw;

    localparam int AW = 6;
    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          cen;
    logic          wen;
    logic [DW-1:0] bwen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] q;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [DW-1:0] K1   = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] K3   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [DW-1:0] K4   = 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA;
    localparam logic [DW-1:0] K6   = 128'h11112222_33334444_55556666_77778888;
    localparam logic [DW-1:0] K7   = 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0001;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] LANE = 128'hFFFF_FFFF_FFFF_FF00_FFFF_FFFF_FFFF_FFFF;

    s011hd1p_x32y2d128_bw #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .CEN (cen),
        .WEN (wen),
        .BWEN(bwen),
        .A   (addr),
        .D   (din),
        .Q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be);
        cen = 1'b0; wen = 1'b0; addr = a; din = d; bwen = be;
        tick();
        cen = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        cen = 1'b0; wen = 1'b1; addr = a; din = '0; bwen = ONES;
        tick();
        cen = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'h9E3779B9 * (k + 1);
        return {w, ~w, w ^ 32'h5A5A5A5A, 32'(k)};
    endfunction

    initial begin
        rst = 1'b1; cen = 1'b1; wen = 1'b1; bwen = ONES; addr = '0; din = '0;
        tick();
        tick();
        check("reset_q", q, '0);
        rst = 1'b0;

        // Full write then immediate read of the same address.
        do_write(6'd5, K1, '0);
        do_read(6'd5);
        check("write_read_a5", q, K1);

        // Byte-lane write: only bits [71:64] take the new (zero) data.
        do_write(6'd7, ONES, '0);
        do_write(6'd7, '0, ~(ONES & 128'hFF << 64));
        do_read(6'd7);
        check("byte_lane_a7", q, LANE);

        // All-ones mask writes nothing.
        do_write(6'd5, '0, ONES);
        do_read(6'd5);
        check("mask_all_ones", q, K1);

        // Idle and write cycles hold Q.
        do_read(6'd7);
        check("read_a7_again", q, LANE);
        do_read(6'd5);
        check("hold_base", q, K1);
        cen = 1'b1; wen = 1'b1; addr = 6'd7; din = ~K1; bwen = '0;
        tick();
        check("idle_hold_rd", q, K1);
        cen = 1'b1; wen = 1'b0; addr = 6'd5; din = ~K1; bwen = '0;
        tick();
        check("idle_hold_wr", q, K1);
        do_write(6'd5, K3, '0);
        check("write_hold_q", q, K1);
        do_read(6'd5);
        check("read_new_a5", q, K3);

        // Reset drops a same-cycle write and clears Q.
        do_write(6'd9, K4, '0);
        do_read(6'd9);
        check("q_nonzero", q, K4);
        cen = 1'b0; wen = 1'b0; addr = 6'd9; din = ~K4; bwen = '0;
        pulse_reset();
        check("reset_clears_q", q, '0);
        do_read(6'd9);
`ifdef SRAM_CLEAR_ON_RESET_EN
        check("a9_after_reset", q, '0);
`else
        check("a9_after_reset", q, K4);
`endif
        do_read(6'd5);
`ifdef SRAM_CLEAR_ON_RESET_EN
        check("a5_after_reset", q, '0);
`else
        check("a5_after_reset", q, K3);
`endif

        // Boundary addresses across a reset pulse.
        do_write(6'd0, K6, '0);
        do_write(6'd63, K7, '0);
        pulse_reset();
        do_read(6'd0);
`ifdef SRAM_CLEAR_ON_RESET_EN
        check("a0_after_reset", q, '0);
`else
        check("a0_after_reset", q, K6);
`endif
        do_read(6'd63);
`ifdef SRAM_CLEAR_ON_RESET_EN
        check("a63_after_reset", q, '0);
`else
        check("a63_after_reset", q, K7);
`endif

        // Streaming: fill, then back-to-back reads with no idle cycles between them.
        for (int k = 0; k < 64; k++) begin
            do_write(AW'(k), pat(k), '0);
        end
        cen = 1'b0; wen = 1'b1; bwen = ONES; din = '0;
        for (int k = 0; k < 64; k++) begin
            addr = AW'(k);
            tick();
            check($sformatf("stream_a%0d", k), q, pat(k));
        end
        cen = 1'b1;
        tick();
        check("stream_hold", q, pat(63));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
